as5600_i2c_slave: RTL and testbench

AS5600_I2C_SLAVE -- requirements
Module: as5600_i2c_slave

---
 rtl/as5600_i2c_slave.sv | 145 ++++++++++++++
 tb/tb_as5600_i2c_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/as5600_i2c_slave.sv
// as5600_i2c_slave: I2C responder exposing a 12-bit angle snapshot as two readable bytes
module as5600_i2c_slave #(
    parameter logic [6:0] I2C_ADDR  = 7'h36,
    parameter logic [7:0] REG_ANGLE = 8'h0E
) (
    input  logic        rstn,
    input  logic        clk,
    input  logic        scl,
    inout  wire         sda,
    input  logic [11:0] i_phi,
    output logic        o_busy,
    output logic        o_rd_done
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, TX_ACK, IGNORE} state_t;

    state_t      state_q;
    logic [1:0]  scl_s_q, sda_s_q;
    logic        scl_p_q, sda_p_q;
    logic [3:0]  cnt_q;
    logic [7:0]  sr_q, ptr_q;
    logic [11:0] shadow_q;
    logic        rw_q, ptr_set_q, sda_oe_q;
    logic        scl_s, sda_s, scl_rise, scl_fall, start, stop, addr_hit;
    logic [7:0]  cur_byte, nxt_byte;

    function automatic logic [7:0] tx_byte(input logic [7:0] p, input logic [11:0] s);
        return p == REG_ANGLE ? {4'h0, s[11:8]} : p == REG_ANGLE + 8'd1 ? s[7:0] : 8'h00;
    endfunction

    assign scl_s    = scl_s_q[1];
    assign sda_s    = sda_s_q[1];
    assign scl_rise = scl_s & ~scl_p_q;
    assign scl_fall = ~scl_s & scl_p_q;
    assign start    = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop     = scl_s & scl_p_q & ~sda_p_q & sda_s;
    assign addr_hit = sr_q[6:0] == I2C_ADDR;
    assign cur_byte = tx_byte(ptr_q, shadow_q);
    assign nxt_byte = tx_byte(ptr_q + 8'd1, shadow_q);
    assign sda      = sda_oe_q ? 1'b0 : 1'bz;

    // two-flop synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            scl_s_q <= 2'b11;
            sda_s_q <= 2'b11;
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_s_q <= {scl_s_q[0], scl};
            sda_s_q <= {sda_s_q[0], sda};
            scl_p_q <= scl_s;
            sda_p_q <= sda_s;
        end

    // protocol FSM; START/STOP override every state, SDA changes only on scl falling edges
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sr_q      <= 8'h00;
            ptr_q     <= REG_ANGLE;
            shadow_q  <= 12'h000;
            rw_q      <= 1'b0;
            ptr_set_q <= 1'b0;
            sda_oe_q  <= 1'b0;
            o_busy    <= 1'b0;
            o_rd_done <= 1'b0;
        end else begin
            o_rd_done <= 1'b0;
            if (start) begin
                state_q  <= ADDR;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
            end else if (stop) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                o_busy   <= 1'b0;
            end else case (state_q)
                ADDR: if (scl_rise) begin
                    sr_q  <= {sr_q[6:0], sda_s};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rw_q    <= sda_s;
                        o_busy  <= addr_hit;
                        state_q <= addr_hit ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_q <= 1'b1;
                        if (rw_q) shadow_q <= i_phi;
                    end else if (rw_q) begin
                        sr_q     <= {cur_byte[6:0], 1'b0};
                        sda_oe_q <= ~cur_byte[7];
                        cnt_q    <= 4'd1;
                        state_q  <= TX;
                    end else begin
                        sda_oe_q  <= 1'b0;
                        cnt_q     <= 4'd0;
                        ptr_set_q <= 1'b0;
                        state_q   <= PTR;
                    end
                end
                PTR: if (scl_rise) begin
                    sr_q  <= {sr_q[6:0], sda_s};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (!ptr_set_q) ptr_q <= {sr_q[6:0], sda_s};
                        ptr_set_q <= 1'b1;
                        state_q   <= PTR_ACK;
                    end
                end
                PTR_ACK: if (scl_fall) begin
                    sda_oe_q <= ~sda_oe_q;
                    if (sda_oe_q) begin
                        cnt_q   <= 4'd0;
                        state_q <= PTR;
                    end
                end
                TX: if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= TX_ACK;
                    end else begin
                        sda_oe_q <= ~sr_q[7];
                        sr_q     <= {sr_q[6:0], 1'b0};
                        cnt_q    <= cnt_q + 4'd1;
                    end
                end
                TX_ACK: if (scl_rise) begin
                    ptr_q     <= ptr_q + 8'd1;
                    o_rd_done <= ptr_q == REG_ANGLE + 8'd1;
                    if (sda_s) state_q <= IGNORE;
                    else begin
                        sr_q    <= nxt_byte;
                        cnt_q   <= 4'd0;
                        state_q <= TX;
                    end
                end
                default: ;
            endcase
        end

endmodule

// File: tb/tb_as5600_i2c_slave.sv
// tb_as5600_i2c_slave: directed I2C initiator driving table vectors and corner sequences
module tb_as5600_i2c_slave;

    localparam time Q = 50ns;

    typedef struct {
        bit         wr;
        logic [7:0] ptr;
        logic [11:0] phi;
        int         n;
        logic [7:0] e0;
        logic [7:0] e1;
        int         done;
    } vec_t;

    logic        clk, rstn, scl, m_sda_low, o_busy, o_rd_done;
    logic [11:0] i_phi;
    wire         sda;
    int          n_chk, n_fail, rd_cnt;
    vec_t        vecs[6];

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    as5600_i2c_slave dut (
        .rstn(rstn), .clk(clk), .scl(scl), .sda(sda),
        .i_phi(i_phi), .o_busy(o_busy), .o_rd_done(o_rd_done)
    );

    initial clk = 1'b0;
    always #5ns clk = ~clk;

    initial rd_cnt = 0;
    always @(posedge clk) if (o_rd_done === 1'b1) rd_cnt <= rd_cnt + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; #Q; scl = 1'b1; #Q; m_sda_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #Q; scl = 1'b1; #Q; m_sda_low = 1'b0; #Q;
    endtask

    task automatic write_bit(input bit b);
        m_sda_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input bit nack);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            read_bit(x);
            d[i] = x;
        end
        write_bit(nack);
    endtask

    task automatic run_vec(input vec_t v);
        logic a;
        logic [7:0] b;
        int d0;
        d0 = rd_cnt;
        i_phi = v.phi;
        i2c_start();
        if (v.wr) begin
            write_byte(8'h6C, a); check("wr_addr_ack", a, 0);
            write_byte(v.ptr, a); check("ptr_ack", a, 0);
            i2c_start();
        end
        write_byte(8'h6D, a); check("rd_addr_ack", a, 0);
        check("busy_in_xfer", o_busy, 1);
        read_byte(b, v.n == 1); check("rd_byte0", b, v.e0);
        if (v.n == 2) begin
            read_byte(b, 1'b1); check("rd_byte1", b, v.e1);
        end
        i2c_stop(); #Q;
        check("busy_after_stop", o_busy, 0);
        check("rd_done_pulses", rd_cnt - d0, v.done);
    endtask

    initial begin
        logic a;
        logic [7:0] b;
        int d0;
        n_chk = 0; n_fail = 0;
        rstn = 1'b0; scl = 1'b1; m_sda_low = 1'b0; i_phi = 12'h000;
        vecs[0] = '{1'b0, 8'h00, 12'h123, 2, 8'h01, 8'h23, 1};
        vecs[1] = '{1'b1, 8'h0E, 12'hA5C, 2, 8'h0A, 8'h5C, 1};
        vecs[2] = '{1'b1, 8'h0F, 12'h7E9, 1, 8'hE9, 8'h00, 1};
        vecs[3] = '{1'b0, 8'h00, 12'h555, 1, 8'h00, 8'h00, 0};
        vecs[4] = '{1'b1, 8'h0D, 12'h456, 2, 8'h00, 8'h04, 0};
        vecs[5] = '{1'b1, 8'hFF, 12'hFFF, 2, 8'h00, 8'h00, 0};
        #33ns;
        check("reset_busy", o_busy, 0);
        check("reset_rd_done", o_rd_done, 0);
        check("reset_sda", sda, 1);
        #40ns rstn = 1'b1;
        #100ns;

        foreach (vecs[i]) run_vec(vecs[i]);

        // pointer left at 0x01 by the wrap: 13 zero bytes, then the high byte at 0x0E
        i_phi = 12'hB37;
        i2c_start();
        write_byte(8'h6D, a); check("wrap_addr_ack", a, 0);
        for (int i = 0; i < 14; i++) begin
            read_byte(b, i == 13);
            check($sformatf("wrap_byte%0d", i), b, i == 13 ? 8'h0B : 8'h00);
        end
        i2c_stop(); #Q;

        // wrong address: NACK and every following byte ignored
        i2c_start();
        write_byte(8'h70, a); check("bad_addr_nack", a, 1);
        check("bad_addr_busy", o_busy, 0);
        write_byte(8'h6D, a); check("ignored_byte0_nack", a, 1);
        write_byte(8'h00, a); check("ignored_byte1_nack", a, 1);
        i2c_stop(); #Q;
        run_vec('{1'b0, 8'h00, 12'h2C4, 1, 8'hC4, 8'h00, 1});

        // snapshot: i_phi changes between the two bytes of one read
        d0 = rd_cnt;
        i_phi = 12'h0FF;
        i2c_start();
        write_byte(8'h6C, a); check("snap_wr_ack", a, 0);
        write_byte(8'h0E, a); check("snap_ptr_ack", a, 0);
        i2c_start();
        write_byte(8'h6D, a); check("snap_rd_ack", a, 0);
        read_byte(b, 1'b0); check("snap_hi", b, 8'h00);
        i_phi = 12'h100;
        read_byte(b, 1'b1); check("snap_lo", b, 8'hFF);
        i2c_stop(); #Q;
        check("snap_rd_done", rd_cnt - d0, 1);

        // reset while the responder is holding a 0 data bit
        i2c_start();
        write_byte(8'h6D, a); check("mid_addr_ack", a, 0);
        check("mid_bit_driven", sda, 0);
        #1ns rstn = 1'b0;
        #1ns check("mid_reset_sda", sda, 1);
        check("mid_reset_busy", o_busy, 0);
        #30ns rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            read_bit(a);
            check("post_reset_idle", a, 1);
        end
        i2c_stop(); #Q;
        run_vec('{1'b1, 8'h0E, 12'h9C3, 2, 8'h09, 8'hC3, 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
